// File: rtl/mdu_pkg.sv
// Types and constants for the iterative multiply/divide unit.
`include "sys_defs.svh"

package mdu_pkg;

    localparam int DW = `DATA_WIDTH;

    // Down-counter width; it is loaded with DW-1 and steps to zero.
    localparam int MDU_CNT_W = $clog2(DW);
    localparam logic [MDU_CNT_W-1:0] MDU_CNT_LOAD = MDU_CNT_W'(DW - 1);

    typedef enum logic [2:0] {
        MDU_MUL   = 3'd0,
        MDU_MULHU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_REM   = 3'd4,
        MDU_REMU  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= MDU_REMU;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide.
// Multiply: acc = {partial high, remaining multiplier}, shifts right.
// Divide:   acc = {partial remainder, dividend/quotient}, shifts left.
module mdu_step
    import mdu_pkg::*;
(
    input  logic            is_div,
    input  logic [2*DW-1:0] acc,
    input  logic [DW-1:0]   operand,
    output logic [2*DW-1:0] acc_next,
    output logic            q_bit
);

    logic [DW:0] mul_sum;
    logic [DW:0] rem_shift;
    logic [DW:0] rem_diff;

    // Single combinational step; the borrow bit of the trial subtract picks the quotient bit.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, operand} : {(DW+1){1'b0}});
        rem_shift = {acc[2*DW-1:DW], acc[DW-1]};
        rem_diff  = rem_shift - {1'b0, operand};
        q_bit     = 1'b0;
        acc_next  = {mul_sum, acc[DW-1:1]};
        if (is_div) begin
            q_bit    = ~rem_diff[DW];
            acc_next = {(q_bit ? rem_diff[DW-1:0] : rem_shift[DW-1:0]), acc[DW-2:0], q_bit};
        end
    end

endmodule

// File: rtl/sys_defs.svh
// System-wide datapath definitions shared by execute-stage units.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define DATA_WIDTH 64

`endif

// File: rtl/exe_mdu_ctrl.sv
// Iterative multiply/divide sequencer beside the execute stage.
//
// state | meaning
// IDLE  | ready for a new operation
// CALC  | one multiply/divide step per cycle, counter counts down to 0
// DONE  | result held until writeback takes it
module exe_mdu_ctrl
    import mdu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_rd,
    input  logic [DW-1:0] op1,
    input  logic [DW-1:0] op2,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic [4:0]    resp_rd,
    output logic          busy
);

    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    mdu_state_e           state;
    logic [MDU_CNT_W-1:0] cnt;
    logic [2:0]           op_q;
    logic [2*DW-1:0]      acc;
    logic [DW-1:0]        operand_q;
    logic                 neg_q;
    logic                 neg_r;

    logic [2*DW-1:0]      acc_next;
    logic                 q_bit;

    logic                 acc_div;
    logic                 req_div;
    logic                 req_signed;
    logic [DW-1:0]        mag1;
    logic [DW-1:0]        mag2;
    logic                 special;
    logic [DW-1:0]        special_data;
    logic [DW-1:0]        quot;
    logic [DW-1:0]        rem;
    logic [DW-1:0]        final_data;

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_DONE);
    assign acc_div    = is_div_op(op_q);

    mdu_step u_step (
        .is_div   (acc_div),
        .acc      (acc),
        .operand  (operand_q),
        .acc_next (acc_next),
        .q_bit    (q_bit)
    );

    // Accept-time decode: operand magnitudes and results that need no iteration.
    always_comb begin
        req_div      = is_div_op(req_op);
        req_signed   = is_signed_op(req_op);
        mag1         = (req_signed && op1[DW-1]) ? (~op1 + 1'b1) : op1;
        mag2         = (req_signed && op2[DW-1]) ? (~op2 + 1'b1) : op2;
        special      = 1'b0;
        special_data = '0;
        if (!is_legal_op(req_op)) begin
            special = 1'b1;
        end else if (req_div && (op2 == '0)) begin
            special      = 1'b1;
            special_data = ((req_op == MDU_DIV) || (req_op == MDU_DIVU)) ? {DW{1'b1}} : op1;
        end else if (req_signed && (op1 == MOST_NEG) && (op2 == {DW{1'b1}})) begin
            special      = 1'b1;
            special_data = (req_op == MDU_DIV) ? op1 : '0;
        end
    end

    // Final step result with sign correction applied to quotient and remainder.
    always_comb begin
        quot = {acc_next[DW-1:1], q_bit};
        rem  = acc_next[2*DW-1:DW];
        case (op_q)
            MDU_MUL:            final_data = acc_next[DW-1:0];
            MDU_MULHU:          final_data = acc_next[2*DW-1:DW];
            MDU_DIV, MDU_DIVU:  final_data = neg_q ? (~quot + 1'b1) : quot;
            MDU_REM, MDU_REMU:  final_data = neg_r ? (~rem + 1'b1) : rem;
            default:            final_data = '0;
        endcase
    end

    // Sequencer FSM: reset beats flush, flush beats any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= MDU_MUL;
            acc       <= '0;
            operand_q <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            resp_data <= '0;
            resp_rd   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        resp_rd <= req_rd;
                        cnt     <= MDU_CNT_LOAD;
                        if (special) begin
                            resp_data <= special_data;
                            state     <= ST_DONE;
                        end else begin
                            acc       <= {{DW{1'b0}}, (req_div ? mag1 : op2)};
                            operand_q <= req_div ? mag2 : op1;
                            neg_q     <= req_signed && (op1[DW-1] ^ op2[DW-1]);
                            neg_r     <= req_signed && op1[DW-1];
                            state     <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        resp_data <= final_data;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_mdu_ctrl.sv
// Scoreboard bench for exe_mdu_ctrl.
module tb_exe_mdu_ctrl;
    import mdu_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [63:0] op1 = '0;
    logic [63:0] op2 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        busy;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t e_mon;

    exe_mdu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .op1        (op1),
        .op2        (op2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Completed handshakes pop the scoreboard.
    always @(negedge clk) begin
        if (!rst && !flush && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("resp_pending", 64'(exp_q.size()), 64'd1);
            end else begin
                e_mon = exp_q.pop_front();
                chk("resp_data", resp_data, e_mon.data);
                chk("resp_rd", {59'b0, resp_rd}, {59'b0, e_mon.rd});
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] expv, input int exp_lat);
        int n;
        bit rdy_low;
        exp_t e;
        chk("req_ready_idle", {63'b0, req_ready}, 64'd1);
        e.data = expv;
        e.rd   = rd;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        op1       = a;
        op2       = b;
        req_rd    = rd;
        step();
        req_valid = 1'b0;
        op1       = {$urandom, $urandom};
        op2       = {$urandom, $urandom};
        req_rd    = 5'($urandom);
        n = 1;
        rdy_low = 1'b1;
        while (!resp_valid && n < 200) begin
            if (req_ready) rdy_low = 1'b0;
            step();
            n++;
        end
        if (req_ready) rdy_low = 1'b0;
        chk("latency", 64'(n), 64'(exp_lat));
        chk("req_ready_low", {63'b0, rdy_low}, 64'd1);
        step();
    endtask

    initial begin
        int  n;
        bit  seen;
        exp_t e;

        repeat (3) step();
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_rd", {59'b0, resp_rd}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        rst = 1'b0;
        step();
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);

        do_op(MDU_MUL,   64'd7, 64'd6, 5'd1, 64'd42, 65);
        do_op(MDU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'd1, 65);
        do_op(MDU_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        do_op(MDU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        do_op(MDU_DIVU,  64'd99, 64'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op(MDU_REMU,  64'd13, 64'd0, 5'd6, 64'd13, 1);
        do_op(MDU_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'h8000_0000_0000_0000, 1);
        do_op(MDU_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'd0, 1);
        do_op(3'd6,      64'd5, 64'd3, 5'd11, 64'd0, 1);
        do_op(MDU_DIV,   64'd1000, 64'hFFFF_FFFF_FFFF_FFF7, 5'd12, 64'hFFFF_FFFF_FFFF_FF91, 65);
        do_op(MDU_REM,   64'd1000, 64'hFFFF_FFFF_FFFF_FFF7, 5'd13, 64'd1, 65);

        // Backpressure, then back-to-back accept after release.
        resp_ready = 1'b0;
        e.data = 64'd14;
        e.rd   = 5'd9;
        exp_q.push_back(e);
        req_valid = 1'b1; req_op = MDU_DIVU; op1 = 64'd100; op2 = 64'd7; req_rd = 5'd9;
        step();
        req_op = MDU_REMU; req_rd = 5'd10;
        n = 1;
        while (!resp_valid && n < 200) begin
            step();
            n++;
        end
        chk("bp_latency", 64'(n), 64'd65);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {63'b0, resp_valid}, 64'd1);
            chk("bp_data", resp_data, 64'd14);
            chk("bp_req_ready", {63'b0, req_ready}, 64'd0);
            step();
        end
        resp_ready = 1'b1;
        e.data = 64'd2;
        e.rd   = 5'd10;
        exp_q.push_back(e);
        step();
        chk("b2b_idle_ready", {63'b0, req_ready}, 64'd1);
        chk("b2b_idle_busy", {63'b0, busy}, 64'd0);
        step();
        req_valid = 1'b0;
        chk("b2b_accept_busy", {63'b0, busy}, 64'd1);
        n = 1;
        while (!resp_valid && n < 200) begin
            step();
            n++;
        end
        chk("b2b_latency", 64'(n), 64'd65);
        step();

        // Flush mid-CALC: the result must never appear.
        req_valid = 1'b1; req_op = MDU_MUL; op1 = 64'd123; op2 = 64'd456; req_rd = 5'd14;
        step();
        req_valid = 1'b0;
        repeat (19) step();
        chk("pre_flush_busy", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        chk("flush_req_ready", {63'b0, req_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (resp_valid) seen = 1'b1;
            step();
        end
        chk("flush_no_resp", {63'b0, seen}, 64'd0);

        // Flush coinciding with a request in IDLE: request is not taken.
        flush = 1'b1; req_valid = 1'b1; req_op = MDU_MUL;
        step();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_accept_busy", {63'b0, busy}, 64'd0);

        do_op(MDU_MUL, 64'd3, 64'd5, 5'd15, 64'd15, 65);

        // Reset mid-CALC.
        req_valid = 1'b1; req_op = MDU_DIVU; op1 = 64'd77; op2 = 64'd3; req_rd = 5'd20;
        step();
        req_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        chk("midrst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("midrst_resp_data", resp_data, 64'd0);
        chk("midrst_resp_rd", {59'b0, resp_rd}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        rst = 1'b0;
        step();
        chk("midrst_req_ready", {63'b0, req_ready}, 64'd1);

        do_op(MDU_DIVU, 64'd77, 64'd3, 5'd21, 64'd25, 65);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_mdu_ctrl.md
# exe_mdu_ctrl

Iterative multiply/divide sequencer beside the execute stage. Accepts one M-type operation at a time from issue through a valid/ready handshake and latches the operands. Runs a one-bit-per-cycle shift-add multiply or restoring divide over `DATA_WIDTH` cycles, then holds the result until writeback takes it. Exports `busy` so the pipeline control can stall dependent instructions.

## Interface
- `DATA_WIDTH`: comes from `sys_defs.svh` (64). Operand/result width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous kill of any in-flight operation.
- `req_valid` in 1: issue presents an operation.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 3: `mdu_op_e` encoding.
- `req_rd` in 5: destination register index, returned with the result.
- `op1`, `op2` in `DATA_WIDTH`: dividend/multiplicand, divisor/multiplier.
- `resp_valid` out 1: result available (DONE state).
- `resp_ready` in 1: writeback consumes result.
- `resp_data` out `DATA_WIDTH`: result.
- `resp_rd` out 5: latched `req_rd`.
- `busy` out 1: state != IDLE.

## Operation
- Op encoding: MUL=0 (low W of unsigned product), MULHU=1 (high W), DIV=2, DIVU=3, REM=4, REMU=5. Codes 6 and 7 are illegal and give result 0.
- States: IDLE, CALC, DONE.
- IDLE: `req_ready`=1.
  - Accept on `req_valid && req_ready`: latch op, operands, rd; load counter with `DATA_WIDTH-1`.
  - Go to CALC, or go straight to DONE for a special case.
- Special cases resolved at accept, with the result written directly:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = op1.
  - Signed overflow (op1 = most-negative value, op2 = -1): DIV = op1; REM = 0.
  - Illegal op: 0.
- CALC:
  - Multiply: one shift-add step per cycle into a 2W accumulator.
  - Divide: one restoring step per cycle on magnitudes. Signed ops first take absolute values of the latched operands.
  - Counter decrements each cycle. When the counter is 0, apply the final correction and go to DONE:
    - Negate the quotient if the operand signs differ.
    - The remainder takes the dividend's sign.
- DONE: `resp_valid`=1 and `resp_data`/`resp_rd` are stable. On `resp_ready`, go to IDLE.
- `flush` (any state) → IDLE next cycle; the result is discarded and no `resp_valid` follows.
- `rst` has priority over `flush`. Both have priority over the handshake.
- Operand inputs are ignored after acceptance.

## Timing
- Reset values:
  - state=IDLE, `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `busy`=0.
  - `req_ready`=1 from the first cycle after reset deasserts.
- `req_ready`, `busy` and `resp_valid` decode from registered state; there is no combinational path from `req_*` to `req_ready`.
- Normal latency, with the accept edge as cycle 0:
  - CALC occupies cycles 1..`DATA_WIDTH`.
  - `resp_valid` first high in cycle `DATA_WIDTH+1` (65 for W=64).
- Special-case latency: `resp_valid` high in cycle 1.
- Backpressure: DONE is held indefinitely while `resp_ready`=0, and `req_ready` stays 0.
- Throughput: after a DONE handshake at edge T, state is IDLE in the cycle after T, so the next accept is at the earliest at edge T+1. There is no accept in the same cycle as a response.
- `flush` together with an accept in IDLE: the flush wins and the request is not taken.
- `rst` mid-CALC: all outputs return to reset values on the next edge.

## Structure
- `mdu_pkg` holds:
  - `mdu_op_e` (3-bit enum above).
  - `mdu_state_e` (IDLE/CALC/DONE).
  - A helper constant for the counter width, `$clog2(DATA_WIDTH)`.
- `DATA_WIDTH` stays in `sys_defs.svh`.
- One sub-module, `mdu_step`: purely combinational single iteration.
  - Inputs: mode, accumulator/remainder, operand.
  - Outputs: next accumulator/remainder and quotient bit.
  - `exe_mdu_ctrl` holds the FSM, counter, registers and sign correction.

## Test plan
- MUL op1=7, op2=6, `resp_ready`=1 → `resp_data`=42, `resp_valid` exactly in cycle 65 after accept, `req_ready`=0 in cycles 1..65.
- MULHU op1=0xFFFF_FFFF_FFFF_FFFF, op2=2 → 1. Then DIV op1=-7, op2=2 → -3, and REM with the same operands → -1. `resp_rd` matches each `req_rd`.
- DIVU op2=0 → all ones in cycle 1; REMU op1=13, op2=0 → 13. DIV op1=0x8000_0000_0000_0000, op2=-1 → op1; REM with the same operands → 0.
- Hold `resp_ready`=0 for 10 cycles in DONE → `resp_valid` and `resp_data` stable, `req_valid` not accepted. Release → IDLE next cycle, back-to-back accept succeeds.
- Assert `flush` in cycle 20 of CALC → `busy`=0 next cycle and no `resp_valid`. A new MUL 3×5 then returns 15.
- Assert `rst` mid-CALC → all outputs at reset values next cycle, `req_ready`=1 after release.
